// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - direct-mapped icache line refill controller (optional ICACHE_NEXT_LINE_PREFETCH_EN)
module icache_refill_ctrl #(
    parameter int          INDEX_W         = 4,
    parameter logic [15:0] MISS_COUNT_INIT = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [15:0]          req_addr,
    input  logic                 hit,
    output logic                 stall,
    output logic                 mem_req,
    output logic [15:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic [63:0]          mem_rdata,
    output logic                 fill_we,
    output logic [INDEX_W-1:0]   fill_index,
    output logic [12-INDEX_W:0]  fill_tag,
    output logic [63:0]          fill_data,
    output logic [15:0]          miss_count
);

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
    typedef enum logic [2:0] {IDLE, REQ, FILL, PF_REQ, PF_FILL} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
`endif

    state_t      state, next_state;
    logic [15:0] line_addr;
    logic        pend;
    logic        demand_miss;
    logic        count_en;

    assign demand_miss = req_valid & ~hit;
    assign mem_addr    = line_addr;

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        count_en   = 1'b0;
        case (state)
            IDLE: begin
                stall = demand_miss;
                // a miss already counted while it waited behind a prefetch is not counted again
                count_en = demand_miss & ~pend;
                if (demand_miss)
                    next_state = REQ;
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack)
                    next_state = FILL;
            end
            FILL: begin
                stall = 1'b1;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                next_state = PF_REQ;
`else
                next_state = IDLE;
`endif
            end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
            PF_REQ: begin
                stall    = pend | demand_miss;
                count_en = demand_miss & ~pend;
                if (mem_ack)
                    next_state = PF_FILL;
            end
            PF_FILL: begin
                stall      = pend | demand_miss;
                count_en   = demand_miss & ~pend;
                next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            line_addr  <= 16'h0000;
            mem_req    <= 1'b0;
            fill_we    <= 1'b0;
            fill_index <= '0;
            fill_tag   <= '0;
            fill_data  <= 64'h0;
            miss_count <= MISS_COUNT_INIT;
            pend       <= 1'b0;
        end else begin
            state <= next_state;
            if (count_en && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
            case (state)
                IDLE: begin
                    pend <= 1'b0;
                    if (demand_miss) begin
                        line_addr <= {req_addr[15:3], 3'b000};
                        mem_req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        fill_we    <= 1'b1;
                        fill_data  <= mem_rdata;
                        fill_index <= line_addr[INDEX_W+2:3];
                        fill_tag   <= line_addr[15:INDEX_W+3];
                    end
                end
                FILL: begin
                    fill_we <= 1'b0;
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                    line_addr <= line_addr + 16'd8;
                    mem_req   <= 1'b1;
`endif
                end
`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
                PF_REQ: begin
                    if (demand_miss)
                        pend <= 1'b1;
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        fill_we    <= 1'b1;
                        fill_data  <= mem_rdata;
                        fill_index <= line_addr[INDEX_W+2:3];
                        fill_tag   <= line_addr[15:INDEX_W+3];
                    end
                end
                PF_FILL: begin
                    fill_we <= 1'b0;
                    if (demand_miss)
                        pend <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        hit;
    logic        stall, mem_req, mem_ack, fill_we;
    logic [15:0] mem_addr, miss_count;
    logic [63:0] mem_rdata, fill_data;
    logic [3:0]  fill_index;
    logic [8:0]  fill_tag;

    logic        s_stall, s_mem_req, s_fill_we;
    logic [15:0] s_mem_addr, s_miss_count;
    logic [63:0] s_fill_data;
    logic [3:0]  s_fill_index;
    logic [8:0]  s_fill_tag;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl #(.INDEX_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
        .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .fill_we(fill_we), .fill_index(fill_index),
        .fill_tag(fill_tag), .fill_data(fill_data), .miss_count(miss_count)
    );

    // Same stimulus, counter starting near saturation.
    icache_refill_ctrl #(.INDEX_W(4), .MISS_COUNT_INIT(16'hFFFD)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .hit(hit),
        .stall(s_stall), .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .fill_we(s_fill_we), .fill_index(s_fill_index),
        .fill_tag(s_fill_tag), .fill_data(s_fill_data), .miss_count(s_miss_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_miss(input string tag, input logic [15:0] addr, input int k,
                           input logic [63:0] data, input logic [15:0] exp_maddr,
                           input logic [3:0] exp_idx, input logic [8:0] exp_tag,
                           input logic [15:0] exp_cnt);
        int          stalls = 0;
        int          first_req = -1;
        int          nfill = 0;
        bit          fill_seen = 0;
        bit          done = 0;
        logic [15:0] req_maddr = 16'h0;
        logic [63:0] cap_data = 64'h0;
        logic [3:0]  cap_idx = 4'h0;
        logic [8:0]  cap_tag = 9'h0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int c = 0; c < 40; c++) begin
            mem_ack   = (c == k);
            mem_rdata = (c == k) ? data : 64'h0;
            hit       = fill_seen;
            @(negedge clk);
            if (mem_req && first_req < 0) begin
                first_req = c;
                req_maddr = mem_addr;
            end
            if (fill_we) begin
                fill_seen = 1;
                nfill++;
                cap_data = fill_data;
                cap_idx  = fill_index;
                cap_tag  = fill_tag;
            end
            if (stall) stalls++;
            else done = 1;
            next_cycle();
            if (done) break;
        end
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_stalls"}, stalls, k + 2);
        check({tag, "_req_lat"}, first_req, 1);
        check({tag, "_mem_addr"}, req_maddr, exp_maddr);
        check({tag, "_nfill"}, nfill, 1);
        check({tag, "_fill_index"}, cap_idx, exp_idx);
        check({tag, "_fill_tag"}, cap_tag, exp_tag);
        check({tag, "_fill_data"}, cap_data, data);
        check({tag, "_miss_count"}, miss_count, exp_cnt);
    endtask

    initial begin
        bit bad;
        rst = 1'b1; req_valid = 1'b0; req_addr = 16'h0; hit = 1'b0;
        mem_ack = 1'b0; mem_rdata = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_fill_we", fill_we, 1'b0);
        check("rst_fill_index", fill_index, 4'h0);
        check("rst_fill_tag", fill_tag, 9'h0);
        check("rst_fill_data", fill_data, 64'h0);
        check("rst_miss_count", miss_count, 16'h0);
        req_valid = 1'b1;
        #1;
        check("rst_stall_comb", stall, 1'b1);
        req_valid = 1'b0;
        next_cycle();
        rst = 1'b0;

        // Start a miss, then reset in the middle of REQ.
        req_valid = 1'b1; req_addr = 16'h0040; hit = 1'b0;
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("midreq_mem_req", mem_req, 1'b1);
        check("midreq_count", miss_count, 16'h1);
        #1 rst = 1'b1;
        #1;
        check("midreq_rst_mem_req", mem_req, 1'b0);
        check("midreq_rst_count", miss_count, 16'h0);
        check("midreq_rst_sat_count", s_miss_count, 16'hFFFD);
        check("midreq_rst_stall", stall, 1'b0);
        next_cycle();
        rst = 1'b0;
        mem_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fill_we || mem_req || stall) bad = 1;
            next_cycle();
        end
        mem_ack = 1'b0;
        check("late_ack_ignored", bad, 1'b0);

`ifdef ICACHE_NEXT_LINE_PREFETCH_EN
        req_valid = 1'b1; req_addr = 16'h0100; hit = 1'b0;
        @(negedge clk);
        check("pf_miss_stall", stall, 1'b1);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 64'hA5A5_0000_1111_2222;
        @(negedge clk);
        check("pf_dreq_addr", mem_addr, 16'h0100);
        next_cycle();
        mem_ack = 1'b0; hit = 1'b1;
        @(negedge clk);
        check("pf_dfill_we", fill_we, 1'b1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("pf_req", mem_req, 1'b1);
        check("pf_req_addr", mem_addr, 16'h0108);
        check("pf_req_stall", stall, 1'b0);
        next_cycle();
        req_valid = 1'b1; req_addr = 16'h0108; hit = 1'b0;
        @(negedge clk);
        check("pf_pend_stall0", stall, 1'b1);
        next_cycle();
        mem_ack = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        check("pf_pend_stall1", stall, 1'b1);
        next_cycle();
        mem_ack = 1'b0;
        @(negedge clk);
        check("pf_fill_we", fill_we, 1'b1);
        check("pf_fill_index", fill_index, 4'h1);
        check("pf_fill_data", fill_data, 64'h0123_4567_89AB_CDEF);
        check("pf_fill_stall", stall, 1'b1);
        next_cycle();
        hit = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (stall || mem_req) bad = 1;
            next_cycle();
        end
        check("pf_no_third_req", bad, 1'b0);
        check("pf_miss_count", miss_count, 16'h2);
        check("pf_sat_count", s_miss_count, 16'hFFFF);
`else
        do_miss("m12", 16'h0012, 3, 64'h1111_2222_3333_4444, 16'h0010, 4'd2, 9'h000, 16'd1);
        check("m12_sat_count", s_miss_count, 16'hFFFE);
        do_miss("mfffe", 16'hFFFE, 1, 64'hDEAD_BEEF_CAFE_F00D, 16'hFFF8, 4'd15, 9'h1FF, 16'd2);
        check("mfffe_sat_count", s_miss_count, 16'hFFFF);

        bad = 0;
        req_valid = 1'b1; hit = 1'b1; mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_addr = 16'(i * 2);
            @(negedge clk);
            if (stall || mem_req || fill_we) bad = 1;
            next_cycle();
        end
        req_valid = 1'b0; mem_ack = 1'b0;
        check("hits_quiet", bad, 1'b0);

        do_miss("m1238", 16'h1238, 2, 64'h0F0E_0D0C_0B0A_0908, 16'h1238, 4'd7, 9'h024, 16'd3);
        check("sat_hold", s_miss_count, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
